// File: rtl/pla_sweep_capture.sv
// rtl/pla_sweep_capture.sv - exhaustive stimulus sweep and MISR/ones-count capture around a 9-input PLA function
// Optional truth-table capture store and read port: define PLA_TT_CAPTURE_EN.
`timescale 1ns/1ps
module pla_sweep_capture #(
  parameter int                N_IN     = 9,
  parameter int                DUT_LAT  = 0,
  parameter int                SIG_W    = 16,
  parameter logic [SIG_W-1:0]  SIG_POLY = 16'h1021,
  parameter logic [SIG_W-1:0]  SIG_SEED = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              y_i,
`ifdef PLA_TT_CAPTURE_EN
  input  logic [N_IN-1:0]   tt_rd_addr_i,
  output logic              tt_rd_data_o,
`endif
  output logic [N_IN-1:0]   vec_o,
  output logic              vec_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [SIG_W-1:0]  signature_o,
  output logic [N_IN:0]     ones_o
);

  // Vector counter is one bit wider than the stimulus so the last vector is unambiguous.
  localparam logic [N_IN:0] LAST_VEC = {1'b0, {N_IN{1'b1}}};

  // Drain counter only needs to reach DUT_LAT-1; keep at least one bit.
  localparam int DCW = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'((DUT_LAT > 0) ? (DUT_LAT - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             launch;
  logic             last_vec;
  logic [N_IN:0]    vcnt;
  logic [DCW-1:0]   drain_cnt;
  logic             sample_en;
  logic             fb;
  logic [SIG_W-1:0] misr_nxt;

  assign last_vec = (vcnt == LAST_VEC);
  assign vec_o    = vcnt[N_IN-1:0];
  assign busy_o   = (state == S_SWEEP) || (state == S_DRAIN);
  assign done_o   = (state == S_DONE);

  // State register; reset aborts any sweep in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is honoured only when not busy.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_nxt = S_SWEEP;
          launch    = 1'b1;
        end
      end
      S_SWEEP: begin
        if (last_vec) begin
          state_nxt = (DUT_LAT > 0) ? S_DRAIN : S_DONE;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stimulus generator: issue 0..2^N_IN-1 once each, then hold the last vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      vcnt        <= '0;
      vec_valid_o <= 1'b0;
    end else if (launch) begin
      vcnt        <= '0;
      vec_valid_o <= 1'b1;
    end else if (state == S_SWEEP) begin
      if (last_vec) begin
        vec_valid_o <= 1'b0;
      end else begin
        vcnt <= vcnt + 1'b1;
      end
    end
  end

  // Drain timer: counts the pipeline latency after the last vector leaves.
  always_ff @(posedge clk) begin
    if (rst || (state != S_DRAIN)) begin
      drain_cnt <= '0;
    end else begin
      drain_cnt <= drain_cnt + 1'b1;
    end
  end

  // Align the sample strobe with the function's pipeline latency.
  generate
    if (DUT_LAT == 0) begin : g_no_lat
      assign sample_en = vec_valid_o;
    end else begin : g_lat
      logic [DUT_LAT-1:0] vpipe;
      // Shift vec_valid_o through DUT_LAT flops.
      always_ff @(posedge clk) begin
        if (rst) begin
          vpipe <= '0;
        end else begin
          vpipe <= (vpipe << 1) | DUT_LAT'(vec_valid_o);
        end
      end
      assign sample_en = vpipe[DUT_LAT-1];
    end
  endgenerate

  // Galois-form MISR step for the current response bit.
  always_comb begin
    fb       = signature_o[SIG_W-1] ^ y_i;
    misr_nxt = {signature_o[SIG_W-2:0], 1'b0} ^ (fb ? SIG_POLY : {SIG_W{1'b0}});
  end

  // Response compaction: signature and ones count, restarted on every launch.
  always_ff @(posedge clk) begin
    if (rst || launch) begin
      signature_o <= SIG_SEED;
      ones_o      <= '0;
    end else if (sample_en) begin
      signature_o <= misr_nxt;
      ones_o      <= ones_o + (N_IN+1)'(y_i);
    end
  end

`ifdef PLA_TT_CAPTURE_EN
  logic            tt_mem [0:(1<<N_IN)-1];
  logic [N_IN-1:0] samp_idx;

  // Sample index tracks which vector the current response belongs to.
  always_ff @(posedge clk) begin
    if (rst || launch) begin
      samp_idx <= '0;
    end else if (sample_en) begin
      samp_idx <= samp_idx + 1'b1;
    end
  end

  // Truth-table store; deliberately not cleared, each sweep rewrites every entry.
  always_ff @(posedge clk) begin
    if (sample_en) begin
      tt_mem[samp_idx] <= y_i;
    end
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      tt_rd_data_o <= 1'b0;
    end else begin
      tt_rd_data_o <= tt_mem[tt_rd_addr_i];
    end
  end
`endif

endmodule

// File: tb/tb_pla_sweep_capture.sv
// tb/tb_pla_sweep_capture.sv - randomized self-checking bench for pla_sweep_capture (latency 0 and 2 instances)
`timescale 1ns/1ps
module tb_pla_sweep_capture;

  localparam int NV = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic        y0, y2;
  logic [8:0]  vec0, vec2;
  logic        val0, val2, busy0, busy2, done0, done2;
  logic [15:0] sig0, sig2;
  logic [9:0]  ones0, ones2;
`ifdef PLA_TT_CAPTURE_EN
  logic [8:0]  tt_addr;
  logic        tt_data0, tt_data2;
`endif

  int   mode;
  logic rnd_tt [0:NV-1];
  logic [8:0] d1 = '0;
  logic [8:0] d2 = '0;

  int n_tests = 0;
  int n_fail  = 0;

  pla_sweep_capture #(.DUT_LAT(0)) u_dut (
    .clk(clk), .rst(rst), .start_i(start), .y_i(y0),
`ifdef PLA_TT_CAPTURE_EN
    .tt_rd_addr_i(tt_addr), .tt_rd_data_o(tt_data0),
`endif
    .vec_o(vec0), .vec_valid_o(val0), .busy_o(busy0), .done_o(done0),
    .signature_o(sig0), .ones_o(ones0)
  );

  pla_sweep_capture #(.DUT_LAT(2)) u_lat (
    .clk(clk), .rst(rst), .start_i(start), .y_i(y2),
`ifdef PLA_TT_CAPTURE_EN
    .tt_rd_addr_i(tt_addr), .tt_rd_data_o(tt_data2),
`endif
    .vec_o(vec2), .vec_valid_o(val2), .busy_o(busy2), .done_o(done2),
    .signature_o(sig2), .ones_o(ones2)
  );

  function automatic logic fy(input int m, input logic [8:0] v);
    case (m)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return v[0];
      3:       return v[8];
      default: return rnd_tt[v];
    endcase
  endfunction

  always_comb y0 = fy(mode, vec0);
  always_comb y2 = fy(mode, d2);

  // Two-flop pipelined copy of the function for the latency-2 instance.
  always @(posedge clk) begin
    d1 <= vec2;
    d2 <= d1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int m, output logic [15:0] s, output logic [9:0] o);
    logic y;
    s = 16'hFFFF;
    o = '0;
    for (int v = 0; v < NV; v++) begin
      y = fy(m, 9'(v));
      if (s[15] ^ y) s = (s << 1) ^ 16'h1021;
      else           s = s << 1;
      o = o + 10'(y);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_vec0"},  32'(vec0),  32'd0);
    check({tag, "_val0"},  32'(val0),  32'd0);
    check({tag, "_busy0"}, 32'(busy0), 32'd0);
    check({tag, "_done0"}, 32'(done0), 32'd0);
    check({tag, "_sig0"},  32'(sig0),  32'hFFFF);
    check({tag, "_ones0"}, 32'(ones0), 32'd0);
    check({tag, "_val2"},  32'(val2),  32'd0);
    check({tag, "_done2"}, 32'(done2), 32'd0);
    check({tag, "_sig2"},  32'(sig2),  32'hFFFF);
    check({tag, "_ones2"}, 32'(ones2), 32'd0);
`ifdef PLA_TT_CAPTURE_EN
    check({tag, "_tt0"},   32'(tt_data0), 32'd0);
`endif
  endtask

  task automatic sweep(input string nm, input int m, input int mid_start, input int abort_at);
    int cyc, d0c, d2c, bad;
    bit ab;
    logic [15:0] es;
    logic [9:0]  eo;
    mode = m;
    model(m, es, eo);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1; d0c = 0; d2c = 0; bad = 0; ab = 1'b0;
    while ((d0c == 0 || d2c == 0) && cyc < 2000 && !ab) begin
      @(negedge clk);
      if (cyc >= 1 && cyc <= NV) begin
        if (vec0 !== 9'(cyc-1) || val0 !== 1'b1 || busy0 !== 1'b1 ||
            vec2 !== 9'(cyc-1) || val2 !== 1'b1 || busy2 !== 1'b1) bad++;
      end
      if (cyc == NV+1) begin
        if (val0 !== 1'b0 || vec0 !== 9'h1FF || val2 !== 1'b0 || vec2 !== 9'h1FF) bad++;
      end
      if (done0 === 1'b1 && d0c == 0) d0c = cyc;
      if (done2 === 1'b1 && d2c == 0) d2c = cyc;
      if (abort_at != 0 && cyc == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset({nm, "_rst"});
        rst = 1'b0;
        ab = 1'b1;
      end else begin
        if (mid_start != 0 && cyc == mid_start) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc++;
      end
    end
    if (!ab) begin
      check({nm, "_done_cyc0"}, 32'(d0c), 32'(NV+1));
      check({nm, "_done_cyc2"}, 32'(d2c), 32'(NV+3));
      check({nm, "_vecseq"},    32'(bad), 32'd0);
      check({nm, "_sig0"},      32'(sig0),  32'(es));
      check({nm, "_ones0"},     32'(ones0), 32'(eo));
      check({nm, "_sig2"},      32'(sig2),  32'(es));
      check({nm, "_ones2"},     32'(ones2), 32'(eo));
      repeat (3) @(negedge clk);
      check({nm, "_sig_hold"},  32'(sig0),  32'(es));
      check({nm, "_done_hold"}, 32'(done0 & ~busy0), 32'd1);
    end
  endtask

`ifdef PLA_TT_CAPTURE_EN
  task automatic tt_check(input string nm, input int m);
    int bad0, bad2;
    bad0 = 0; bad2 = 0;
    for (int a = 0; a <= NV; a++) begin
      @(negedge clk);
      if (a > 0) begin
        if (tt_data0 !== fy(m, 9'(a-1))) bad0++;
        if (tt_data2 !== fy(m, 9'(a-1))) bad2++;
      end
      if (a < NV) tt_addr = 9'(a);
    end
    check({nm, "_tt0"}, 32'(bad0), 32'd0);
    check({nm, "_tt2"}, 32'(bad2), 32'd0);
  endtask
`endif

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 0;
`ifdef PLA_TT_CAPTURE_EN
    tt_addr = '0;
`endif
    for (int i = 0; i < NV; i++) rnd_tt[i] = 1'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    sweep("zero", 0, 0, 0);
    sweep("one",  1, 0, 0);
    sweep("lsb",  2, 0, 0);
    sweep("msb",  3, 0, 0);
`ifdef PLA_TT_CAPTURE_EN
    tt_check("msb", 3);
`endif
    sweep("rnd_midstart", 4, 100, 0);
`ifdef PLA_TT_CAPTURE_EN
    tt_check("rnd", 4);
`endif
    for (int i = 0; i < NV; i++) rnd_tt[i] = 1'($urandom);
    sweep("abort", 4, 0, 200);
    sweep("after_abort", 4, 0, 0);
`ifdef PLA_TT_CAPTURE_EN
    tt_check("after_abort", 4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
